// File: rtl/alu_cmd_issuer_if.sv
// Command / ALU / result bundle for alu_cmd_issuer.
// done_count exists only when ALU_CMD_STATS_EN is defined.
interface alu_cmd_issuer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [OP_W-1:0]   cmd_opcode;
    logic              cmd_in_sel;
    logic [DATA_W-1:0] alu_in_a;
    logic [DATA_W-1:0] alu_in_b;
    logic [OP_W-1:0]   alu_opcode;
    logic              alu_in_sel;
    logic              alu_enable;
    logic [DATA_W-1:0] alu_out;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [OP_W-1:0]   res_opcode;
    logic [CNT_W-1:0]  fifo_count;
`ifdef ALU_CMD_STATS_EN
    logic [15:0]       done_count;
`endif

    // Environment side: producer, ALU and consumer.
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_in_sel, alu_out, res_ready,
        input  cmd_ready, alu_in_a, alu_in_b, alu_opcode, alu_in_sel, alu_enable,
               res_valid, res_data, res_opcode, fifo_count
`ifdef ALU_CMD_STATS_EN
        , input done_count
`endif
    );

    // Issuer side.
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_in_sel, alu_out, res_ready,
        output cmd_ready, alu_in_a, alu_in_b, alu_opcode, alu_in_sel, alu_enable,
               res_valid, res_data, res_opcode, fifo_count
`ifdef ALU_CMD_STATS_EN
        , output done_count
`endif
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands in a FIFO, issues them one at a time and returns results via valid/ready.
// Define ALU_CMD_STATS_EN to add the saturating done_count result counter.
module alu_cmd_issuer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_cmd_issuer_if.slave  bus
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam int unsigned ENT_W = 2 * DATA_W + OP_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              alu_sel_q, alu_sel_d;
    logic              alu_en_q, alu_en_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [OP_W-1:0]   res_op_q, res_op_d;
    logic              push;
    logic              pop;

    // FIFO storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_opcode, bus.cmd_in_sel};
    end

    // Next-state: FSM, FIFO pointers/occupancy and issue/result registers.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_sel_d   = alu_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        pop         = 1'b0;
        push        = bus.cmd_valid && cmd_ready_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (lat_q == '0) begin
                    res_data_d  = bus.alu_out;
                    res_op_d    = alu_op_q;
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            {alu_a_d, alu_b_d, alu_op_d, alu_sel_d} = mem_q[rd_ptr_q];
            lat_d = LAT_W'(ALU_LAT - 1);
        end

        alu_en_d = (state_d == S_EXEC);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        cmd_ready_d = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            lat_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_sel_q   <= 1'b0;
            alu_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            lat_q       <= lat_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_sel_q   <= alu_sel_d;
            alu_en_q    <= alu_en_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.alu_in_a   = alu_a_q;
    assign bus.alu_in_b   = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.alu_in_sel = alu_sel_q;
    assign bus.alu_enable = alu_en_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_opcode = res_op_q;
    assign bus.fifo_count = count_q;

`ifdef ALU_CMD_STATS_EN
    logic [15:0] done_q, done_d;

    // Saturating count of accepted results.
    always_comb begin
        done_d = done_q;
        if (res_valid_q && bus.res_ready && (done_q != 16'hFFFF)) done_d = done_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) done_q <= '0;
        else       done_q <= done_d;
    end

    assign bus.done_count = done_q;
`endif

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Upstream command stage for the 8-bit ALU. Buffers operand/opcode commands from a producer in a small FIFO, then issues them one at a time onto the ALU input ports (in_a, in_b, opcode, in_sel, enable). After a fixed latency it captures the ALU out value and presents it downstream with a valid/ready handshake. Serialises ALU use and decouples producer and consumer timing.

Parameters:
DATA_W, 8, operand and result width.
OP_W, 4, opcode width.
DEPTH, 4, command FIFO depth; power of two, at least 2.
ALU_LAT, 1, cycles enable is held before alu_out is sampled; at least 1.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
cmd_valid  input  1  producer has a command.
cmd_ready  output  1  FIFO can accept a command.
cmd_a  input  DATA_W  operand A.
cmd_b  input  DATA_W  operand B.
cmd_opcode  input  OP_W  ALU opcode.
cmd_in_sel  input  1  ALU input select (1 selects A, 0 selects B).
alu_in_a  output  DATA_W  to ALU in_a.
alu_in_b  output  DATA_W  to ALU in_b.
alu_opcode  output  OP_W  to ALU opcode.
alu_in_sel  output  1  to ALU in_sel.
alu_enable  output  1  to ALU enable.
alu_out  input  DATA_W  from ALU out.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts the result.
res_data  output  DATA_W  captured ALU result.
res_opcode  output  OP_W  opcode that produced res_data.
fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate): FIFO empty, pointers 0, fifo_count 0, state IDLE. All alu_* outputs 0, res_valid 0, res_data 0, res_opcode 0. cmd_ready is 1 once reset is released.
- Push: occurs when cmd_valid and cmd_ready. cmd_ready = (fifo_count < DEPTH). A full FIFO does not accept a push, even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH. A push and a pop in the same cycle leave fifo_count unchanged.
- State IDLE: if fifo_count > 0, pop the head into the alu_* registers and go to EXEC. Otherwise stay in IDLE.
- State EXEC: alu_enable = 1 for exactly ALU_LAT cycles, counted by a down-counter.
  - On the clock edge ending the last EXEC cycle, register alu_out into res_data and alu_opcode into res_opcode, then go to RESP.
- State RESP: res_valid = 1, and res_data/res_opcode hold stable until accepted.
  - res_valid && res_ready with FIFO non-empty: pop the next command and go straight to EXEC.
  - res_valid && res_ready with FIFO empty: go to IDLE.
  - Otherwise stay in RESP; the FIFO keeps accepting pushes.
- alu_enable = 0 in IDLE and RESP. alu_in_a, alu_in_b, alu_opcode and alu_in_sel hold the last issued command until the next pop.
- Latency: for a command pushed into an empty idle block in cycle c0, alu_enable is high in cycles c2..c1+ALU_LAT and res_valid rises in cycle c2+ALU_LAT.
- Back-to-back throughput with res_ready held at 1: one result every ALU_LAT+1 cycles.
- Ordering: results leave strictly in push order.
- Reset mid-operation: the in-flight command and all queued commands are discarded, and alu_enable drops immediately.

Optional Feature:
Macro ALU_CMD_STATS_EN.
- Defined: adds output done_count (16 bits). It resets to 0, increments on each res_valid && res_ready, and saturates at 16'hFFFF.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
The bench uses a stub ALU with alu_out = alu_in_a + alu_in_b when alu_enable = 1, else 0. ALU_LAT = 1, DEPTH = 4.
1. Single command, res_ready = 1: push A=11, B=2, opcode=0 in cycle 0 -> alu_enable high only in cycle 2; res_valid in cycle 3 with res_data=13, res_opcode=0; fifo_count returns to 0.
2. Fill: hold res_ready=0 and push 6 commands (A=i, B=1, opcode=i for i=1..6) -> cmd_ready drops after 5 accepted (1 issued plus 4 queued); the 6th is held until the first result is accepted.
3. Ordering: release res_ready=1 after scenario 2 -> res_data sequence 2, 3, 4, 5, 6, 7 with opcodes 1..6; results every 2 cycles; no gaps or duplicates.
4. Simultaneous push and pop: with fifo_count=2, push while the block pops in RESP -> fifo_count stays 2.
5. Reset mid-EXEC: assert reset while alu_enable=1 -> alu_enable, res_valid and fifo_count go to 0 without a clock edge; the next command after release returns its correct sum.
6. ALU_CMD_STATS_EN defined: 3 accepted results -> done_count=3; stays 0 while res_ready=0.
